// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 style RAM arbiter: FSM states, owner
// encoding and default RAM geometry.
package sap1_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LD  = 1'b1
    } owner_t;

    localparam int RAM_AW = 4;
    localparam int RAM_DW = 8;

endpackage

// File: rtl/mem_arb.sv
// Arbiter/sequencer for the shared 16x8 RAM: CPU vs front-panel loader, fixed
// IDLE->SETUP->ACCESS->DONE cycle. Optional macro MEM_ARB_LD_PEEK_EN lets the loader read in run mode.
//
// Handshake: a requester holds req (and its we/addr/wdata) until it sees its
// one-cycle ack, then drops req on that same edge; rdata is valid with ack and
// held until the next read by the same requester. ld_err marks a rejected
// loader request and only ever pulses together with ld_ack.
module mem_arb
    import sap1_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW
) (
    input  logic          CLK,
    input  logic          nCLR,
    input  logic          run,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    output logic          ld_err,
    output logic [DW-1:0] ld_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          ram_nCE,
    output logic          ram_nWE,
    output logic          busy,
    output logic [1:0]    fsm_state
);

`ifdef MEM_ARB_LD_PEEK_EN
    localparam bit PEEK_EN = 1'b1;
`else
    localparam bit PEEK_EN = 1'b0;
`endif

    state_t state;
    owner_t owner;
    logic   we_r;

    logic grant_cpu;
    logic grant_ld;
    logic reject_ld;

    // In program mode the CPU simply stalls; only the loader can be rejected.
    assign grant_cpu = run & cpu_req;
    assign grant_ld  = ld_req & (~run | (~cpu_req & PEEK_EN & ~ld_we));
    assign reject_ld = ld_req & run & ~cpu_req & ~(PEEK_EN & ~ld_we);

    assign fsm_state = state;

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state     <= IDLE;
            owner     <= OWN_CPU;
            we_r      <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_nCE   <= 1'b1;
            ram_nWE   <= 1'b1;
            cpu_ack   <= 1'b0;
            ld_ack    <= 1'b0;
            ld_err    <= 1'b0;
            cpu_rdata <= '0;
            ld_rdata  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_cpu || grant_ld) begin
                        state     <= SETUP;
                        busy      <= 1'b1;
                        owner     <= grant_cpu ? OWN_CPU : OWN_LD;
                        we_r      <= grant_cpu ? cpu_we : ld_we;
                        ram_addr  <= grant_cpu ? cpu_addr : ld_addr;
                        ram_wdata <= grant_cpu ? cpu_wdata : ld_wdata;
                    end else if (reject_ld) begin
                        state  <= DONE;
                        busy   <= 1'b1;
                        ld_ack <= 1'b1;
                        ld_err <= 1'b1;
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                    if (we_r) ram_nWE <= 1'b0;
                    else      ram_nCE <= 1'b0;
                end
                ACCESS: begin
                    state   <= DONE;
                    ram_nCE <= 1'b1;
                    ram_nWE <= 1'b1;
                    if (owner == OWN_CPU) begin
                        cpu_ack <= 1'b1;
                        if (!we_r) cpu_rdata <= ram_rdata;
                    end else begin
                        ld_ack <= 1'b1;
                        if (!we_r) ld_rdata <= ram_rdata;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    cpu_ack <= 1'b0;
                    ld_ack  <= 1'b0;
                    ld_err  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
